// File: rtl/pairhmm_wb_sched.sv
// Write-back scheduler: round-robin arbitration of engine results into the
// host-visible result buffer, with buffer-full and batch-done handshakes.
module pairhmm_wb_sched #(
    parameter int N_ENG        = 4,
    parameter int DW           = 128,
    parameter int AW           = 14,
    parameter int MAX_DATA_NUM = 16384
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               cpu_pkt_done,
    input  logic               read_done,
    input  logic [N_ENG-1:0]    res_vld,
    input  logic [N_ENG*DW-1:0] res_data,
    input  logic [N_ENG-1:0]    eng_last,
    output logic [N_ENG-1:0]    res_ack,
    output logic                eng_start,
    output logic [DW-1:0]       data_write_pcie,
    output logic [AW-1:0]       addr_write_pcie,
    output logic                en_write_pcie,
    output logic [AW:0]         data_num,
    output logic                max_data_num_done,
    output logic                data_done
);

    localparam int            PW       = (N_ENG > 1) ? $clog2(N_ENG) : 1;
    localparam logic [AW:0]   MAX_CNT  = (AW+1)'(MAX_DATA_NUM);
    localparam logic [PW-1:0] LAST_ENG = PW'(N_ENG - 1);

    typedef enum logic [2:0] {IDLE, START, RUN, FULL_WAIT, DONE_WAIT} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant_idx;
    logic [PW-1:0] cand;
    logic          grant_vld;
    logic          ack_en;
    logic          fill;
    logic          last_too;
    logic          batch_end;
    logic          first_run;
    logic [AW-1:0] addr;

    // Round-robin search starting at rr_ptr; first requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < N_ENG; k++) begin
            cand = PW'((int'(rr_ptr) + k) % N_ENG);
            if (!grant_vld && res_vld[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // eng_last is ignored during the first RUN cycle so engines can clear it.
    always_comb begin
        ack_en    = (state == RUN) && grant_vld;
        res_ack   = ack_en ? (N_ENG'(1) << grant_idx) : '0;
        fill      = ack_en && ((data_num + 1'b1) == MAX_CNT);
        last_too  = fill && !first_run && (&eng_last) && ((res_vld & ~res_ack) == '0);
        batch_end = (state == RUN) && !first_run && (&eng_last) && (res_vld == '0);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (cpu_pkt_done) state_nxt = START;
            START:     state_nxt = RUN;
            RUN: begin
                if (fill)           state_nxt = last_too ? DONE_WAIT : FULL_WAIT;
                else if (batch_end) state_nxt = DONE_WAIT;
            end
            FULL_WAIT: if (read_done) state_nxt = RUN;
            DONE_WAIT: if (read_done) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            addr              <= '0;
            first_run         <= 1'b0;
            eng_start         <= 1'b0;
            data_write_pcie   <= '0;
            addr_write_pcie   <= '0;
            en_write_pcie     <= 1'b0;
            data_num          <= '0;
            max_data_num_done <= 1'b0;
            data_done         <= 1'b0;
        end else begin
            state         <= state_nxt;
            eng_start     <= (state == IDLE) && cpu_pkt_done;
            first_run     <= (state == START);
            en_write_pcie <= ack_en;
            if (ack_en) begin
                data_write_pcie <= res_data[grant_idx*DW +: DW];
                addr_write_pcie <= addr;
                addr            <= addr + 1'b1;
                data_num        <= data_num + 1'b1;
                rr_ptr          <= (grant_idx == LAST_ENG) ? '0 : grant_idx + 1'b1;
            end
            if (fill) max_data_num_done <= 1'b1;
            if (batch_end || last_too) data_done <= 1'b1;
            case (state)
                START: begin
                    addr     <= '0;
                    data_num <= '0;
                end
                FULL_WAIT: if (read_done) begin
                    max_data_num_done <= 1'b0;
                    addr              <= '0;
                    data_num          <= '0;
                end
                DONE_WAIT: if (read_done) begin
                    max_data_num_done <= 1'b0;
                    data_done         <= 1'b0;
                    addr              <= '0;
                    data_num          <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule
